// File: rtl/eight_bit_exponential_decay_lookup.sv
// Registered exponential-decay ROM for the ADSR envelope: dout = round(255 * e^(-din/32)),
// available one clock after din is sampled.
module eight_bit_exponential_decay_lookup (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Precomputed floor(255 * e^(-i/32) + 0.5); eight entries per row, row base index on the right.
    localparam logic [7:0] DECAY_ROM [256] = '{
        8'd255, 8'd247, 8'd240, 8'd232, 8'd225, 8'd218, 8'd211, 8'd205, //   0
        8'd199, 8'd192, 8'd187, 8'd181, 8'd175, 8'd170, 8'd165, 8'd160, //   8
        8'd155, 8'd150, 8'd145, 8'd141, 8'd136, 8'd132, 8'd128, 8'd124, //  16
        8'd120, 8'd117, 8'd113, 8'd110, 8'd106, 8'd103, 8'd100, 8'd97,  //  24
        8'd94,  8'd91,  8'd88,  8'd85,  8'd83,  8'd80,  8'd78,  8'd75,  //  32
        8'd73,  8'd71,  8'd69,  8'd67,  8'd64,  8'd62,  8'd61,  8'd59,  //  40
        8'd57,  8'd55,  8'd53,  8'd52,  8'd50,  8'd49,  8'd47,  8'd46,  //  48
        8'd44,  8'd43,  8'd42,  8'd40,  8'd39,  8'd38,  8'd37,  8'd36,  //  56
        8'd35,  8'd33,  8'd32,  8'd31,  8'd30,  8'd30,  8'd29,  8'd28,  //  64
        8'd27,  8'd26,  8'd25,  8'd24,  8'd24,  8'd23,  8'd22,  8'd22,  //  72
        8'd21,  8'd20,  8'd20,  8'd19,  8'd18,  8'd18,  8'd17,  8'd17,  //  80
        8'd16,  8'd16,  8'd15,  8'd15,  8'd14,  8'd14,  8'd14,  8'd13,  //  88
        8'd13,  8'd12,  8'd12,  8'd12,  8'd11,  8'd11,  8'd11,  8'd10,  //  96
        8'd10,  8'd10,  8'd9,   8'd9,   8'd9,   8'd8,   8'd8,   8'd8,   // 104
        8'd8,   8'd7,   8'd7,   8'd7,   8'd7,   8'd7,   8'd6,   8'd6,   // 112
        8'd6,   8'd6,   8'd6,   8'd5,   8'd5,   8'd5,   8'd5,   8'd5,   // 120
        8'd5,   8'd5,   8'd4,   8'd4,   8'd4,   8'd4,   8'd4,   8'd4,   // 128
        8'd4,   8'd4,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   // 136
        8'd3,   8'd3,   8'd3,   8'd3,   8'd2,   8'd2,   8'd2,   8'd2,   // 144
        8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   // 152
        8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd1,   8'd1,   8'd1,   // 160
        8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   // 168
        8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   // 176
        8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   // 184
        8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   // 192
        8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   // 200
        8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   // 208
        8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   // 216
        8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   // 224
        8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   // 232
        8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   // 240
        8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0    // 248
    };

    logic [7:0] dout_d;
    // Power-up and reset value is full scale so a fresh envelope starts at the top of the curve.
    logic [7:0] dout_q = 8'd255;

    always_comb begin
        dout_d = DECAY_ROM[din];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q <= 8'd255;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_eight_bit_exponential_decay_lookup.sv
// Bench for the exponential-decay lookup: expected values are queued when stimulus is driven
// and compared one edge later against a real-arithmetic model of the decay curve.
module tb_eight_bit_exponential_decay_lookup;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'd128;
    logic [7:0] dout;

    logic [7:0] exp_q[$];
    logic       mono_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Clock / reset: 10 ns period; rst starts asserted (active low).
    always #5 clk = ~clk;

    eight_bit_exponential_decay_lookup dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout)
    );

    function automatic logic [7:0] model(input int i);
        real v;
        v = $floor(255.0 * $exp(-real'(i) / 32.0) + 0.5);
        return 8'(int'(v));
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Driver: inputs change on the falling edge; the result is due at the next rising edge.
    task automatic drive_exp(input logic [7:0] d, input logic r, input logic [7:0] e, input logic mono);
        @(negedge clk);
        din = d;
        rst = r;
        exp_q.push_back(e);
        mono_q.push_back(mono);
    endtask

    task automatic drive(input logic [7:0] d, input logic r, input logic mono);
        drive_exp(d, r, r ? model(int'(d)) : 8'd255, mono);
    endtask

    // Scoreboard: sample 1 ns after each rising edge.
    initial begin
        logic [7:0] prev;
        logic       have_prev;
        prev      = 8'd255;
        have_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                logic       m;
                e = exp_q.pop_front();
                m = mono_q.pop_front();
                check_eq("lookup", dout, e);
                if (m && have_prev)
                    check_eq("monotonic", (dout > prev) ? 8'd1 : 8'd0, 8'd0);
                have_prev = m;
                prev      = dout;
            end
        end
    end

    logic [7:0] anchor_in  [12] = '{8'd0, 8'd1, 8'd8, 8'd16, 8'd32, 8'd64,
                                    8'd128, 8'd160, 8'd192, 8'd199, 8'd200, 8'd255};
    logic [7:0] anchor_out [12] = '{8'd255, 8'd247, 8'd199, 8'd155, 8'd94, 8'd35,
                                    8'd5, 8'd2, 8'd1, 8'd1, 8'd0, 8'd0};

    initial begin
        #1;
        check_eq("power_up", dout, 8'd255);

        // Reset held with din = 128, then release.
        for (int i = 0; i < 3; i++) drive_exp(8'd128, 1'b0, 8'd255, 1'b0);
        drive_exp(8'd128, 1'b1, 8'd5, 1'b0);

        // Anchor sweep with literal expectations.
        for (int i = 0; i < 12; i++) drive_exp(anchor_in[i], 1'b1, anchor_out[i], 1'b0);

        // Exhaustive ramp, monotonicity tracked.
        for (int i = 0; i < 256; i++) drive(8'(i), 1'b1, 1'b1);

        // Wrap 255 -> 0.
        drive_exp(8'd0, 1'b1, 8'd255, 1'b0);

        // Latency: alternate 0 / 255 every clock.
        for (int i = 0; i < 10; i++)
            drive_exp((i % 2 == 0) ? 8'd255 : 8'd0, 1'b1, (i % 2 == 0) ? 8'd0 : 8'd255, 1'b0);

        // Reset pulse mid-ramp at din = 64.
        for (int i = 56; i < 80; i++) drive(8'(i), (i == 64) ? 1'b0 : 1'b1, 1'b0);

        // Random lookups with occasional resets.
        for (int i = 0; i < 200; i++)
            drive(8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1, 1'b0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        check_eq("drain", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
